stoch_root_unit: RTL and testbench

Parametrised successor to the team's 6-bit stochastic square-root element. It computes stochastic roots using an up/down counter and a history-product feedback loop. Features:
- configurable counter width and init value;
- run-time mode select: square root, cube root or identity;
- clock enable;
- built-in windowed ones-counter that turns the output bitstream into a binary estimate.

It sits between an RNG bank and downstream stochastic arithmetic or monitoring logic.

---
 rtl/stoch_root_unit.sv | 92 +++++++++
 tb/tb_stoch_root_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stoch_root_unit.sv
// Stochastic root element: up/down counter with history-product feedback, plus a
// windowed ones-counter that turns the output bitstream into a binary estimate.
module stoch_root_unit #(
  parameter int WIDTH   = 6,
  parameter int INIT    = 2 ** (WIDTH - 1),
  parameter int WIN_LOG = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   rand_num,
  input  logic               in,
  input  logic               clr_win,
  output logic               out,
  output logic [WIDTH-1:0]   cnt_o,
  output logic [WIN_LOG:0]   est,
  output logic               est_valid
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]   cnt;
  logic               h1;
  logic               h2;
  logic               dec;
  logic               inc;
  logic [WIN_LOG-1:0] win_cnt;
  logic [WIN_LOG:0]   acc;
  logic [WIN_LOG:0]   acc_next;
  logic               win_last;

  assign out      = (cnt > rand_num);
  assign cnt_o    = cnt;
  assign inc      = in;
  assign win_last = (win_cnt == {WIN_LOG{1'b1}});
  assign acc_next = acc + {{WIN_LOG{1'b0}}, out};

  // Mode 11 falls back to the square-root product.
  always_comb begin
    dec = out & h1;
    case (mode)
      2'b01:   dec = out & h1 & h2;
      2'b10:   dec = out;
      default: dec = out & h1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= INIT_V;
      h1  <= 1'b0;
      h2  <= 1'b0;
    end else if (en) begin
      h1 <= out;
      h2 <= h1;
      if (inc && !dec && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end else if (dec && !inc && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // est_valid is cleared on every edge so a stall can never stretch the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt   <= '0;
      acc       <= '0;
      est       <= '0;
      est_valid <= 1'b0;
    end else begin
      est_valid <= 1'b0;
      if (en) begin
        if (clr_win) begin
          win_cnt <= '0;
          acc     <= '0;
        end else if (win_last) begin
          est       <= acc_next;
          est_valid <= 1'b1;
          acc       <= '0;
          win_cnt   <= '0;
        end else begin
          acc     <= acc_next;
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stoch_root_unit.sv
// Bench for stoch_root_unit: comparator vector table, saturation/enable/window
// sequences, statistical convergence, and a random run against a reference model.
module tb_stoch_root_unit;

  localparam int WIDTH   = 6;
  localparam int WIN_LOG = 10;
  localparam int WIN     = 1 << WIN_LOG;
  localparam int CMAX    = (1 << WIDTH) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   rand_num;
  logic               in;
  logic               clr_win;
  logic               out;
  logic [WIDTH-1:0]   cnt_o;
  logic [WIN_LOG:0]   est;
  logic               est_valid;

  int checks = 0;
  int passes = 0;

  stoch_root_unit #(.WIDTH(WIDTH), .INIT(32), .WIN_LOG(WIN_LOG)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rand_num(rand_num), .in(in),
    .clr_win(clr_win), .out(out), .cnt_o(cnt_o), .est(est), .est_valid(est_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; rand_num = '0; in = 1'b0; clr_win = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual >= lo && actual <= hi) passes++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
  endtask

  // Ticks until est_valid is seen; returns edge count (limit+1 means timeout).
  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!est_valid && n <= limit);
  endtask

  // reference model state
  int     m_cnt;
  bit     m_hist[$];
  int     m_pos;
  int     m_ones;
  int     m_est;
  bit     m_ev;

  function automatic bit model_out(input int r);
    return m_cnt > r;
  endfunction

  function automatic void model_reset();
    m_cnt = 32; m_hist = '{0, 0}; m_pos = 0; m_ones = 0; m_est = 0; m_ev = 0;
  endfunction

  function automatic void model_step(input bit e, input bit [1:0] md, input int r,
                                     input bit i, input bit c);
    bit o;
    bit d;
    m_ev = 0;
    if (!e) return;
    o = model_out(r);
    if (md == 2'b10)      d = o;
    else if (md == 2'b01) d = o && m_hist[0] && m_hist[1];
    else                  d = o && m_hist[0];
    if (i && !d && m_cnt < CMAX)      m_cnt++;
    else if (d && !i && m_cnt > 0)    m_cnt--;
    m_hist.push_front(o);
    void'(m_hist.pop_back());
    if (c) begin
      m_pos = 0; m_ones = 0;
    end else begin
      m_ones += o;
      m_pos++;
      if (m_pos == WIN) begin
        m_est = m_ones; m_ev = 1; m_ones = 0; m_pos = 0;
      end
    end
  endfunction

  typedef struct {
    logic [WIDTH-1:0] rnd;
    logic             exp_out;
  } cmp_vec_t;

  cmp_vec_t vecs[6];

  initial begin
    int n;
    int frozen;
    int last_est;

    vecs[0] = '{6'd31, 1'b1};
    vecs[1] = '{6'd32, 1'b0};
    vecs[2] = '{6'd0,  1'b1};
    vecs[3] = '{6'd63, 1'b0};
    vecs[4] = '{6'd17, 1'b1};
    vecs[5] = '{6'd45, 1'b0};

    // reset values and comparator table (en=0 keeps cnt at 32)
    do_reset();
    check("reset_cnt", int'(cnt_o), 32);
    check("reset_est", int'(est), 0);
    check("reset_est_valid", int'(est_valid), 0);
    foreach (vecs[k]) begin
      rand_num = vecs[k].rnd;
      #1;
      check($sformatf("cmp_rand_%0d", vecs[k].rnd), int'(out), int'(vecs[k].exp_out));
    end

    // upper saturation
    en = 1'b1; in = 1'b1; rand_num = 6'd63; mode = 2'b00;
    for (int k = 0; k < 30; k++) tick();
    check("sat_up_30", int'(cnt_o), 62);
    tick();
    check("sat_up_31", int'(cnt_o), 63);
    for (int k = 0; k < 10; k++) tick();
    check("sat_up_hold", int'(cnt_o), 63);

    // lower saturation in identity mode
    do_reset();
    en = 1'b1; mode = 2'b10; in = 1'b0; rand_num = 6'd0;
    for (int k = 0; k < 32; k++) tick();
    check("sat_dn_32", int'(cnt_o), 0);
    check("sat_dn_out", int'(out), 0);
    for (int k = 0; k < 5; k++) tick();
    check("sat_dn_hold", int'(cnt_o), 0);
    in = 1'b1;
    tick();
    check("dn_inc_from0", int'(cnt_o), 1);
    check("dn_out_now1", int'(out), 1);
    for (int k = 0; k < 4; k++) tick();
    check("inc_dec_cancel", int'(cnt_o), 1);

    // plain window period with en high, and an all-ones window
    do_reset();
    en = 1'b1; mode = 2'b10; in = 1'b1; rand_num = 6'd0;
    wait_pulse(3000, n);
    check("win_period_first", n, WIN);
    check("win_all_ones_est", int'(est), WIN);
    wait_pulse(3000, n);
    check("win_period_second", n, WIN);
    tick();
    check("est_valid_one_cycle", int'(est_valid), 0);

    // asynchronous reset mid-window
    for (int k = 0; k < 300; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cnt", int'(cnt_o), 32);
    check("async_rst_est", int'(est), 0);
    check("async_rst_est_valid", int'(est_valid), 0);
    rst = 1'b0;

    // clr_win at cycle 500 restarts the window
    do_reset();
    en = 1'b1; mode = 2'b00; in = 1'b1; rand_num = 6'd20;
    for (int k = 0; k < 500; k++) tick();
    clr_win = 1'b1;
    tick();
    clr_win = 1'b0;
    check("clr_no_pulse", int'(est_valid), 0);
    wait_pulse(3000, n);
    check("clr_restart_period", n, WIN);

    // 20-cycle stall delays the first window by 20 cycles
    do_reset();
    en = 1'b1; mode = 2'b00;
    for (int k = 0; k < 300; k++) begin
      in = 1'($urandom_range(0, 1)); rand_num = WIDTH'($urandom_range(0, CMAX));
      tick();
    end
    en = 1'b0;
    frozen = int'(cnt_o);
    last_est = 0;
    for (int k = 0; k < 20; k++) begin
      in = 1'($urandom_range(0, 1)); rand_num = WIDTH'($urandom_range(0, CMAX));
      tick();
      if (est_valid || int'(cnt_o) != frozen) last_est++;
    end
    check("stall_frozen", last_est, 0);
    en = 1'b1;
    wait_pulse(3000, n);
    check("stall_window_delay", 300 + 20 + n, WIN + 20);

    // convergence per mode
    for (int md = 0; md < 3; md++) begin
      do_reset();
      en = 1'b1; mode = 2'(md);
      for (int w = 0; w < 4; w++) begin
        n = 0;
        do begin
          case (md)
            0:       in = ($urandom_range(0, 3) == 0);
            1:       in = ($urandom_range(0, 7) == 0);
            default: in = 1'($urandom_range(0, 1));
          endcase
          rand_num = WIDTH'($urandom_range(0, CMAX));
          tick();
          n++;
        end while (!est_valid && n <= 3000);
      end
      check_range($sformatf("converge_mode_%0d", md), int'(est), 512 - 48, 512 + 48);
    end

    // random run against reference model
    do_reset();
    model_reset();
    for (int k = 0; k < 3000; k++) begin
      en       = ($urandom_range(0, 9) < 8);
      mode     = 2'($urandom_range(0, 3));
      in       = 1'($urandom_range(0, 1));
      rand_num = WIDTH'($urandom_range(0, CMAX));
      clr_win  = ($urandom_range(0, 999) == 0);
      #1;
      check("rnd_out", int'(out), int'(model_out(int'(rand_num))));
      model_step(en, mode, int'(rand_num), in, clr_win);
      tick();
      check("rnd_cnt", int'(cnt_o), m_cnt);
      check("rnd_est", int'(est), m_est);
      check("rnd_est_valid", int'(est_valid), int'(m_ev));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
